pipe_stage_regs: RTL and testbench



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/flopenrc.sv | 22 ++
 rtl/pipe_stage_regs.sv | 110 +++++++++++
 tb/tb_pipe_stage_regs.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS front-end pipeline registers.
// Holds the decoded control bundle and the NOP encodings.
package pipe_pkg;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] memtoreg;
    logic       memwrite;
    logic [2:0] alucontrol;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic       branchnot;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t       CTRL_NOP  = '0;
  localparam logic [31:0] INSTR_NOP = 32'h0;

endpackage

// File: rtl/flopenrc.sv
// Register with enable and synchronous clear; clear only acts when enabled.
// Reset and clear both load INIT.
module flopenrc #(
  parameter int           W    = 8,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset)
      q <= INIT;
    else if (en)
      q <= clr ? INIT : d;
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, F->D and D->E pipeline registers with hazard controls,
// saturating stall/flush counters and a sticky protocol-error flag.
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushE,
  input  logic             pcsrcD,
  input  logic [WIDTH-1:0] pcnextF,
  input  logic [WIDTH-1:0] instrF,
  input  logic [WIDTH-1:0] pcplus4F,
  input  ctrl_t            ctrlD,
  input  logic [WIDTH-1:0] rd1D,
  input  logic [WIDTH-1:0] rd2D,
  input  logic [WIDTH-1:0] signimmD,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rdD,
  output logic [WIDTH-1:0] pcF,
  output logic [WIDTH-1:0] instrD,
  output logic [WIDTH-1:0] pcplus4D,
  output logic             validD,
  output ctrl_t            ctrlE,
  output logic [WIDTH-1:0] rd1E,
  output logic [WIDTH-1:0] rd2E,
  output logic [WIDTH-1:0] signimmE,
  output logic [4:0]       rsE,
  output logic [4:0]       rtE,
  output logic [4:0]       rdE,
  output logic             validE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             protocol_err
);

  localparam int DW = 2 * WIDTH + 1;
  localparam int EW = CTRL_W + 3 * WIDTH + 16;

  localparam logic [DW-1:0] D_INIT =
    {WIDTH'(INSTR_NOP), {(WIDTH + 1){1'b0}}};
  localparam logic [EW-1:0] E_INIT =
    {CTRL_NOP, {(EW - CTRL_W){1'b0}}};

  logic [DW-1:0] d_d, d_q;
  logic [EW-1:0] e_d, e_q;
  logic          flush_ev;

  flopenrc #(.W(WIDTH), .INIT(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (~stallF),
    .clr   (1'b0),
    .d     (pcnextF),
    .q     (pcF)
  );

  assign d_d = {instrF, pcplus4F, 1'b1};

  flopenrc #(.W(DW), .INIT(D_INIT)) u_d (
    .clk   (clk),
    .reset (reset),
    .en    (~stallD),
    .clr   (pcsrcD),
    .d     (d_d),
    .q     (d_q)
  );

  assign {instrD, pcplus4D, validD} = d_q;

  assign e_d = {ctrlD, rd1D, rd2D, signimmD,
                rsD, rtD, rdD, validD};

  flopenrc #(.W(EW), .INIT(E_INIT)) u_e (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (flushE),
    .d     (e_d),
    .q     (e_q)
  );

  assign {ctrlE, rd1E, rd2E, signimmE,
          rsE, rtE, rdE, validE} = e_q;

  assign flush_ev = flushE | (pcsrcD & ~stallD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (stallD && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
      // stallF, stallD and flushE must always move together
      if ((stallD != stallF) || (stallD != flushE))
        protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, load, stall, squash,
// protocol error, counter saturation and reset mid-stall.
module tb_pipe_stage_regs;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, flushE, pcsrcD;
  logic [31:0] pcnextF, instrF, pcplus4F;
  ctrl_t       ctrlD;
  logic [31:0] rd1D, rd2D, signimmD;
  logic [4:0]  rsD, rtD, rdD;
  logic [31:0] pcF, instrD, pcplus4D;
  logic        validD;
  ctrl_t       ctrlE;
  logic [31:0] rd1E, rd2E, signimmE;
  logic [4:0]  rsE, rtE, rdE;
  logic        validE;
  logic [15:0] stall_cnt, flush_cnt;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;
  ctrl_t c_ld;

  always #5 clk = ~clk;

  pipe_stage_regs #(
    .WIDTH(32), .RESET_PC(32'h0), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .stallF(stallF), .stallD(stallD),
    .flushE(flushE), .pcsrcD(pcsrcD),
    .pcnextF(pcnextF), .instrF(instrF),
    .pcplus4F(pcplus4F), .ctrlD(ctrlD),
    .rd1D(rd1D), .rd2D(rd2D),
    .signimmD(signimmD),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .pcF(pcF), .instrD(instrD),
    .pcplus4D(pcplus4D), .validD(validD),
    .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E),
    .signimmE(signimmE),
    .rsE(rsE), .rtE(rtE), .rdE(rdE),
    .validE(validE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .protocol_err(protocol_err)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic s, input logic f,
                     input logic p);
    stallF = s;
    stallD = s;
    flushE = f;
    pcsrcD = p;
  endtask

  initial begin
    reset    = 1'b0;
    ctl(0, 0, 0);
    pcnextF  = 32'h40;
    instrF   = 32'h0;
    pcplus4F = 32'h0;
    ctrlD    = CTRL_NOP;
    rd1D     = 32'h0;
    rd2D     = 32'h0;
    signimmD = 32'h0;
    rsD = 5'd0; rtD = 5'd0; rdD = 5'd0;
    c_ld = '{regwrite: 1'b1, memtoreg: 2'b01,
             memwrite: 1'b0, alucontrol: 3'b010,
             alusrc: 1'b1, regdst: 1'b0,
             branch: 1'b0, branchnot: 1'b0};

    step(); step();
    check("rst_pcF", 64'(pcF), 64'h0);
    check("rst_instrD", 64'(instrD), 64'h0);
    check("rst_validD", 64'(validD), 64'h0);
    check("rst_validE", 64'(validE), 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'h0);
    check("rst_perr", 64'(protocol_err), 64'h0);

    reset    = 1'b1;
    instrF   = 32'h8C22_0004;
    pcplus4F = 32'h44;
    ctrlD    = c_ld;
    rd1D     = 32'h1234_5678;
    signimmD = 32'h4;
    rsD = 5'd1; rtD = 5'd2; rdD = 5'd0;
    step();
    check("ld_pcF", 64'(pcF), 64'h40);
    check("ld_instrD", 64'(instrD), 64'h8C22_0004);
    check("ld_pcplus4D", 64'(pcplus4D), 64'h44);
    check("ld_validD", 64'(validD), 64'h1);
    check("ld_validE0", 64'(validE), 64'h0);
    step();
    check("ld_ctrlE", 64'(ctrlE), 64'(c_ld));
    check("ld_validE", 64'(validE), 64'h1);
    check("ld_rd1E", 64'(rd1E), 64'h1234_5678);
    check("ld_rtE", 64'(rtE), 64'd2);

    pcnextF = 32'h80;
    instrF  = 32'h1111_1111;
    ctl(1, 1, 0);
    step();
    check("lu_pcF", 64'(pcF), 64'h40);
    check("lu_instrD", 64'(instrD), 64'h8C22_0004);
    check("lu_ctrlE", 64'(ctrlE), 64'h0);
    check("lu_validE", 64'(validE), 64'h0);
    check("lu_rd1E", 64'(rd1E), 64'h0);
    check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    check("lu_flush_cnt", 64'(flush_cnt), 64'd1);
    check("lu_perr", 64'(protocol_err), 64'h0);

    ctl(0, 0, 0);
    step();
    check("rs_pcF", 64'(pcF), 64'h80);
    check("rs_instrD", 64'(instrD), 64'h1111_1111);
    check("rs_validE", 64'(validE), 64'h1);

    ctl(0, 0, 1);
    step();
    check("br_instrD", 64'(instrD), 64'h0);
    check("br_validD", 64'(validD), 64'h0);
    check("br_flush_cnt", 64'(flush_cnt), 64'd2);
    check("br_stall_cnt", 64'(stall_cnt), 64'd1);

    ctl(0, 0, 0);
    instrF = 32'h2222_2222;
    step();
    check("br2_instrD", 64'(instrD), 64'h2222_2222);
    check("br2_validE", 64'(validE), 64'h0);
    instrF = 32'h3333_3333;
    ctl(1, 1, 1);
    step();
    check("sq_hold_instrD", 64'(instrD), 64'h2222_2222);
    check("sq_hold_validD", 64'(validD), 64'h1);
    check("sq_flush_cnt", 64'(flush_cnt), 64'd3);
    check("sq_stall_cnt", 64'(stall_cnt), 64'd2);
    check("sq_perr", 64'(protocol_err), 64'h0);

    ctl(0, 0, 0);
    stallD = 1'b1;
    step();
    check("pe_set", 64'(protocol_err), 64'h1);
    check("pe_stall_cnt", 64'(stall_cnt), 64'd3);
    check("pe_flush_cnt", 64'(flush_cnt), 64'd3);
    check("pe_validE", 64'(validE), 64'h1);
    ctl(0, 0, 0);
    step(); step(); step();
    check("pe_sticky", 64'(protocol_err), 64'h1);

    reset   = 1'b0;
    pcnextF = 32'h40;
    step();
    check("rst2_perr", 64'(protocol_err), 64'h0);
    check("rst2_stall_cnt", 64'(stall_cnt), 64'h0);
    reset = 1'b1;
    step();
    check("rst2_pcF", 64'(pcF), 64'h40);

    pcnextF = 32'hC0;
    ctl(1, 1, 0);
    for (int i = 1; i <= 70000; i++) begin
      step();
      if (i == 65534)
        check("sat_m1", 64'(stall_cnt), 64'hFFFE);
      if (i == 65535)
        check("sat_at", 64'(stall_cnt), 64'hFFFF);
    end
    check("sat_stall_cnt", 64'(stall_cnt), 64'hFFFF);
    check("sat_flush_cnt", 64'(flush_cnt), 64'hFFFF);
    check("sat_pcF", 64'(pcF), 64'h40);
    check("sat_perr", 64'(protocol_err), 64'h0);

    reset = 1'b0;
    step();
    check("mid_pcF", 64'(pcF), 64'h0);
    check("mid_instrD", 64'(instrD), 64'h0);
    check("mid_validD", 64'(validD), 64'h0);
    check("mid_validE", 64'(validE), 64'h0);
    check("mid_ctrlE", 64'(ctrlE), 64'h0);
    check("mid_stall_cnt", 64'(stall_cnt), 64'h0);
    check("mid_flush_cnt", 64'(flush_cnt), 64'h0);
    check("mid_perr", 64'(protocol_err), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
